// File: rtl/mem_access_unit_if.sv
// Launch/response and RAM bus bundle of the memory-access stage.
// slave: the stage itself; master: the sequencer/RAM side.
interface mem_access_unit_if;
  logic        start_i;
  logic        is_store_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i;
  logic [31:0] store_data_i;
  logic        busy_o;
  logic        done_o;
  logic        fault_o;
  logic [31:0] load_data_o;
  logic        we_o;
  logic [31:0] addr_o;
  logic [31:0] data_i;
  logic [31:0] data_o;

  modport slave (
    input  start_i, is_store_i, funct3_i,
    input  addr_i, store_data_i, data_i,
    output busy_o, done_o, fault_o,
    output load_data_o, we_o, addr_o, data_o
  );

  modport master (
    output start_i, is_store_i, funct3_i,
    output addr_i, store_data_i, data_i,
    input  busy_o, done_o, fault_o,
    input  load_data_o, we_o, addr_o, data_o
  );
endinterface

// File: rtl/mem_access_unit.sv
// RV32 load/store stage; sub-word stores via read-modify-write.
// Ports: clk, reset (sync, active-low), bus (mem_access_unit_if.slave).
module mem_access_unit #(
  parameter int RAM_LATENCY = 1,
  parameter int CHECK_ALIGN = 1
) (
  input logic             clk,
  input logic             reset,
  mem_access_unit_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_MERGE,
    S_WRITE,
    S_DONE
  } state_t;

  localparam int WAIT_INIT =
    (RAM_LATENCY > 1) ? RAM_LATENCY - 2 : 0;

  state_t      r_state;
  logic [1:0]  r_cnt;
  logic        r_store;
  logic [2:0]  r_f3;
  logic [1:0]  r_lane;
  logic [15:0] r_sdata;

  logic        w_illegal;
  logic        w_misal;
  logic        w_fault;
  logic [31:0] w_addr;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [31:0] w_merge;

  // Launch decode; the address is always aligned down, which is
  // identity whenever the alignment check passes.
  always_comb begin
    w_illegal = 1'b0;
    unique case (1'b1)
      bus.funct3_i == 3'b000,
      bus.funct3_i == 3'b001,
      bus.funct3_i == 3'b010: w_illegal = 1'b0;
      bus.funct3_i == 3'b100,
      bus.funct3_i == 3'b101: w_illegal = bus.is_store_i;
      default:                w_illegal = 1'b1;
    endcase
    w_misal = 1'b0;
    if (CHECK_ALIGN != 0) begin
      w_misal =
        (bus.funct3_i[1:0] == 2'b01 && bus.addr_i[0]) ||
        (bus.funct3_i == 3'b010 &&
         bus.addr_i[1:0] != 2'b00);
    end
    w_fault = w_illegal | w_misal;
    w_addr  = bus.addr_i;
    if (bus.funct3_i[1:0] == 2'b01) w_addr[0] = 1'b0;
    if (bus.funct3_i == 3'b010) w_addr[1:0] = 2'b00;
  end

  // Lane extraction for loads, lane insertion for sub-word stores.
  always_comb begin
    w_byte = bus.data_i[7:0];
    unique case (r_lane)
      2'd0: w_byte = bus.data_i[7:0];
      2'd1: w_byte = bus.data_i[15:8];
      2'd2: w_byte = bus.data_i[23:16];
      2'd3: w_byte = bus.data_i[31:24];
    endcase
    w_half = r_lane[1] ? bus.data_i[31:16] : bus.data_i[15:0];
    w_load = bus.data_i;
    unique case (1'b1)
      r_f3 == 3'b000: w_load = {{24{w_byte[7]}}, w_byte};
      r_f3 == 3'b001: w_load = {{16{w_half[15]}}, w_half};
      r_f3 == 3'b100: w_load = {24'd0, w_byte};
      r_f3 == 3'b101: w_load = {16'd0, w_half};
      default:        w_load = bus.data_i;
    endcase
    w_merge = bus.data_i;
    if (r_f3 == 3'b000) begin
      unique case (r_lane)
        2'd0: w_merge[7:0]   = r_sdata[7:0];
        2'd1: w_merge[15:8]  = r_sdata[7:0];
        2'd2: w_merge[23:16] = r_sdata[7:0];
        2'd3: w_merge[31:24] = r_sdata[7:0];
      endcase
    end else if (r_f3 == 3'b001) begin
      if (r_lane[1]) w_merge[31:16] = r_sdata;
      else           w_merge[15:0]  = r_sdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state         <= S_IDLE;
      r_cnt           <= 2'd0;
      r_store         <= 1'b0;
      r_f3            <= 3'd0;
      r_lane          <= 2'd0;
      r_sdata         <= 16'd0;
      bus.busy_o      <= 1'b0;
      bus.done_o      <= 1'b0;
      bus.fault_o     <= 1'b0;
      bus.load_data_o <= 32'd0;
      bus.we_o        <= 1'b0;
      bus.addr_o      <= 32'd0;
      bus.data_o      <= 32'd0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.start_i) begin
            r_store    <= bus.is_store_i;
            r_f3       <= bus.funct3_i;
            r_lane     <= w_addr[1:0];
            r_sdata    <= bus.store_data_i[15:0];
            bus.busy_o <= 1'b1;
            if (w_fault) begin
              r_state     <= S_DONE;
              bus.done_o  <= 1'b1;
              bus.fault_o <= 1'b1;
            end else if (bus.is_store_i &&
                         bus.funct3_i == 3'b010) begin
              r_state    <= S_WRITE;
              bus.we_o   <= 1'b1;
              bus.addr_o <= {w_addr[31:2], 2'b00};
              bus.data_o <= bus.store_data_i;
            end else begin
              r_state    <= S_READ;
              bus.addr_o <= {w_addr[31:2], 2'b00};
            end
          end
        end
        S_READ: begin
          if (RAM_LATENCY <= 1) begin
            r_state <= S_MERGE;
          end else begin
            r_state <= S_WAIT;
            r_cnt   <= 2'(WAIT_INIT);
          end
        end
        S_WAIT: begin
          if (r_cnt == 2'd0) r_state <= S_MERGE;
          else               r_cnt   <= r_cnt - 2'd1;
        end
        S_MERGE: begin
          if (r_store) begin
            r_state    <= S_WRITE;
            bus.we_o   <= 1'b1;
            bus.data_o <= w_merge;
          end else begin
            r_state         <= S_DONE;
            bus.load_data_o <= w_load;
            bus.addr_o      <= 32'd0;
            bus.done_o      <= 1'b1;
          end
        end
        S_WRITE: begin
          r_state    <= S_DONE;
          bus.we_o   <= 1'b0;
          bus.addr_o <= 32'd0;
          bus.data_o <= 32'd0;
          bus.done_o <= 1'b1;
        end
        S_DONE: begin
          r_state     <= S_IDLE;
          bus.done_o  <= 1'b0;
          bus.fault_o <= 1'b0;
          bus.busy_o  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit across latency/alignment variants.
// u0: LAT1/align, u1: LAT3/align, u2: LAT1/no-align.
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_access_unit_if m0 ();
  mem_access_unit_if m1 ();
  mem_access_unit_if m2 ();

  mem_access_unit #(.RAM_LATENCY(1), .CHECK_ALIGN(1)) u0 (
    .clk(clk), .reset(rst_n), .bus(m0));
  mem_access_unit #(.RAM_LATENCY(3), .CHECK_ALIGN(1)) u1 (
    .clk(clk), .reset(rst_n), .bus(m1));
  mem_access_unit #(.RAM_LATENCY(1), .CHECK_ALIGN(0)) u2 (
    .clk(clk), .reset(rst_n), .bus(m2));

  logic [31:0] ram0 [0:255];
  logic [31:0] ram1 [0:255];
  logic [31:0] ram2 [0:255];
  logic [31:0] p0, p1a, p1b, p1c, p2;

  assign m0.data_i = p0;
  assign m1.data_i = p1c;
  assign m2.data_i = p2;

  always @(posedge clk) begin
    if (m0.we_o) ram0[m0.addr_o[9:2]] <= m0.data_o;
    if (m1.we_o) ram1[m1.addr_o[9:2]] <= m1.data_o;
    if (m2.we_o) ram2[m2.addr_o[9:2]] <= m2.data_o;
    p0  <= ram0[m0.addr_o[9:2]];
    p1a <= ram1[m1.addr_o[9:2]];
    p1b <= p1a;
    p1c <= p1b;
    p2  <= ram2[m2.addr_o[9:2]];
  end

  typedef struct {
    int          dut;
    logic        f;
    logic        cd;
    logic [31:0] d;
    int          c;
  } exp_t;

  exp_t  sbq [$];
  string tq [$];
  int    wr_cnt [3];
  int    wr_cyc [3];
  logic [31:0] wr_addr [3];
  int    done_cnt [3];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h",
               tag, got, exp);
    end
  endtask

  task automatic on_done(input int d, input logic dn,
                         input logic f, input logic [31:0] ld);
    exp_t  e;
    string t;
    if (sbq.size() == 0) begin
      check("unexpected_done", {31'd0, dn}, 32'd0);
      return;
    end
    e = sbq.pop_front();
    t = tq.pop_front();
    check({t, "_dut"}, d, e.dut);
    check({t, "_cycle"}, cyc, e.c);
    check({t, "_fault"}, {31'd0, f}, {31'd0, e.f});
    if (e.cd) check({t, "_data"}, ld, e.d);
  endtask

  always @(negedge clk) begin
    if (m0.done_o) begin
      done_cnt[0] <= done_cnt[0] + 1;
      on_done(0, m0.done_o, m0.fault_o, m0.load_data_o);
    end
    if (m1.done_o) begin
      done_cnt[1] <= done_cnt[1] + 1;
      on_done(1, m1.done_o, m1.fault_o, m1.load_data_o);
    end
    if (m2.done_o) begin
      done_cnt[2] <= done_cnt[2] + 1;
      on_done(2, m2.done_o, m2.fault_o, m2.load_data_o);
    end
    if (m0.we_o) begin
      wr_cnt[0]  <= wr_cnt[0] + 1;
      wr_cyc[0]  <= cyc;
      wr_addr[0] <= m0.addr_o;
    end
    if (m1.we_o) wr_cnt[1] <= wr_cnt[1] + 1;
    if (m2.we_o) wr_cnt[2] <= wr_cnt[2] + 1;
  end

  task automatic drive(input int d, input logic s, input logic st,
                       input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd);
    case (d)
      0: begin
        m0.start_i = s; m0.is_store_i = st; m0.funct3_i = f3;
        m0.addr_i = a; m0.store_data_i = sd;
      end
      1: begin
        m1.start_i = s; m1.is_store_i = st; m1.funct3_i = f3;
        m1.addr_i = a; m1.store_data_i = sd;
      end
      default: begin
        m2.start_i = s; m2.is_store_i = st; m2.funct3_i = f3;
        m2.addr_i = a; m2.store_data_i = sd;
      end
    endcase
  endtask

  task automatic launch(input int d, input logic st,
                        input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, input bit push,
                        input logic ef, input logic cd,
                        input logic [31:0] ed, input int lat,
                        input string tag, output int sc);
    @(posedge clk); #1;
    sc = cyc;
    if (push) begin
      sbq.push_back('{d, ef, cd, ed, sc + lat});
      tq.push_back(tag);
    end
    drive(d, 1'b1, st, f3, a, sd);
    @(posedge clk); #1;
    drive(d, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
  endtask

  task automatic settle(input string tag);
    int n = 0;
    while (sbq.size() != 0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_timeout"}, sbq.size(), 0);
    sbq.delete();
    tq.delete();
  endtask

  task automatic op(input int d, input logic st,
                    input logic [2:0] f3, input logic [31:0] a,
                    input logic [31:0] sd, input logic ef,
                    input logic cd, input logic [31:0] ed,
                    input int lat, input string tag,
                    output int sc);
    launch(d, st, f3, a, sd, 1'b1, ef, cd, ed, lat, tag, sc);
    settle(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int sc;
    int w;
    int dc;
    for (int i = 0; i < 3; i++) begin
      wr_cnt[i] = 0; wr_cyc[i] = 0;
      wr_addr[i] = 32'd0; done_cnt[i] = 0;
      drive(i, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {31'd0, m0.busy_o}, 32'd0);
    check("rst_done", {31'd0, m0.done_o}, 32'd0);
    check("rst_fault", {31'd0, m0.fault_o}, 32'd0);
    check("rst_we", {31'd0, m0.we_o}, 32'd0);
    check("rst_addr", m0.addr_o, 32'd0);
    check("rst_wdata", m0.data_o, 32'd0);
    check("rst_ldata", m0.load_data_o, 32'd0);
    check("rst_busy_u1", {31'd0, m1.busy_o}, 32'd0);
    check("rst_busy_u2", {31'd0, m2.busy_o}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    op(0, 1, 3'b010, 32'h100, 32'h8899AABB, 0, 0, 0, 2, "sw100", sc);
    check("sw100_ram", ram0[8'h40], 32'h8899AABB);
    op(0, 0, 3'b000, 32'h101, 0, 0, 1, 32'hFFFFFFAA, 3, "lb", sc);
    op(0, 0, 3'b100, 32'h101, 0, 0, 1, 32'h000000AA, 3, "lbu", sc);
    op(0, 0, 3'b101, 32'h102, 0, 0, 1, 32'h00008899, 3, "lhu", sc);
    op(0, 0, 3'b001, 32'h102, 0, 0, 1, 32'hFFFF8899, 3, "lh", sc);
    op(0, 0, 3'b000, 32'h103, 0, 0, 1, 32'hFFFFFF88, 3, "lb3", sc);
    op(0, 0, 3'b010, 32'h100, 0, 0, 1, 32'h8899AABB, 3, "lw", sc);

    w = wr_cnt[0];
    op(0, 1, 3'b010, 32'h200, 32'h12345678, 0, 0, 0, 2, "sw200", sc);
    check("sw200_wr_count", wr_cnt[0] - w, 1);
    check("sw200_wr_cycle", wr_cyc[0] - sc, 1);
    check("sw200_wr_addr", wr_addr[0], 32'h200);
    check("sw200_ram", ram0[8'h80], 32'h12345678);

    w = wr_cnt[0];
    op(0, 1, 3'b000, 32'h202, 32'hFFFFFFEE, 0, 0, 0, 4, "sb", sc);
    check("sb_wr_count", wr_cnt[0] - w, 1);
    check("sb_ram", ram0[8'h80], 32'h12EE5678);
    op(0, 1, 3'b001, 32'h200, 32'h0000CAFE, 0, 0, 0, 4, "sh", sc);
    check("sh_ram", ram0[8'h80], 32'h12EECAFE);

    w = wr_cnt[0];
    op(0, 0, 3'b010, 32'h103, 0, 1, 1, 32'h8899AABB, 1, "lw_mis", sc);
    op(0, 0, 3'b001, 32'h101, 0, 1, 1, 32'h8899AABB, 1, "lh_mis", sc);
    op(0, 0, 3'b011, 32'h100, 0, 1, 1, 32'h8899AABB, 1, "f3_011", sc);
    op(0, 1, 3'b100, 32'h200, 32'h1, 1, 1, 32'h8899AABB, 1, "sbu", sc);
    op(0, 1, 3'b010, 32'h202, 32'h1, 1, 1, 32'h8899AABB, 1, "sw_mis", sc);
    check("fault_no_write", wr_cnt[0] - w, 0);
    check("fault_ram", ram0[8'h80], 32'h12EECAFE);

    op(2, 1, 3'b010, 32'h100, 32'h8899AABB, 0, 0, 0, 2, "u2_sw", sc);
    op(2, 0, 3'b010, 32'h103, 0, 0, 1, 32'h8899AABB, 3, "u2_lw", sc);
    op(2, 0, 3'b001, 32'h103, 0, 0, 1, 32'hFFFF8899, 3, "u2_lh", sc);
    op(2, 0, 3'b111, 32'h100, 0, 1, 1, 32'hFFFF8899, 1, "u2_f3", sc);
    op(2, 1, 3'b001, 32'h101, 32'h1234, 0, 0, 0, 4, "u2_sh", sc);
    check("u2_sh_ram", ram2[8'h40], 32'h88991234);

    op(1, 1, 3'b010, 32'h100, 32'h8899AABB, 0, 0, 0, 2, "u1_sw", sc);
    dc = done_cnt[1];
    launch(1, 0, 3'b010, 32'h100, 0, 1'b1, 0, 1, 32'h8899AABB, 5,
           "u1_lw", sc);
    @(posedge clk); #1;
    drive(1, 1'b1, 1'b0, 3'b011, 32'h0, 32'h0);
    @(posedge clk); #1;
    drive(1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    settle("u1_lw");
    repeat (8) @(posedge clk);
    #1;
    check("u1_single_done", done_cnt[1] - dc, 1);
    op(1, 1, 3'b000, 32'h101, 32'h11, 0, 0, 0, 6, "u1_sb", sc);
    check("u1_sb_ram", ram1[8'h40], 32'h889911BB);

    w = wr_cnt[0];
    dc = done_cnt[0];
    launch(0, 1, 3'b000, 32'h203, 32'h55, 1'b0, 0, 0, 0, 0,
           "rst_sb", sc);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("mrst_busy", {31'd0, m0.busy_o}, 32'd0);
    check("mrst_we", {31'd0, m0.we_o}, 32'd0);
    check("mrst_addr", m0.addr_o, 32'd0);
    check("mrst_wdata", m0.data_o, 32'd0);
    check("mrst_ldata", m0.load_data_o, 32'd0);
    repeat (6) @(posedge clk);
    #1;
    check("mrst_no_write", wr_cnt[0] - w, 0);
    check("mrst_no_done", done_cnt[0] - dc, 0);
    check("mrst_ram", ram0[8'h80], 32'h12EECAFE);
    op(0, 0, 3'b010, 32'h200, 0, 0, 1, 32'h12EECAFE, 3, "post_lw", sc);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
